// File: rtl/aes_result_serializer.sv
// Captures one DATA_W-bit result from busR and emits it as NWORDS words, MSB word first.
// Optional build macro AES_RESULT_BYTE_SWAP_EN byte-reverses each output word.
module aes_result_serializer #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] busR,
  input  logic              busR_valid,
  output logic              busR_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic              busy
);

  localparam int unsigned NWORDS = DATA_W / WORD_W;
  localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  idx;
  logic [DATA_W-1:0] hold;
  logic [WORD_W-1:0] word_sel;
  logic              capture;
  logic              xfer;
  logic              at_last;

  assign at_last    = (idx == LAST_IDX);
  // Accept a new block when idle, or in the same cycle the final word leaves.
  assign busR_ready = (state == EMPTY) || ((state == SEND) && at_last && word_ready);
  assign capture    = busR_valid && busR_ready;
  assign xfer       = word_valid && word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      idx        <= '0;
      hold       <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      busy       <= 1'b0;
    end else if (capture) begin
      state      <= SEND;
      idx        <= '0;
      hold       <= busR;
      word_valid <= 1'b1;
      word_last  <= (LAST_IDX == '0);
      busy       <= 1'b1;
    end else if (xfer) begin
      if (at_last) begin
        state      <= EMPTY;
        word_valid <= 1'b0;
        word_last  <= 1'b0;
        busy       <= 1'b0;
      end else begin
        idx       <= CNT_W'(idx + 1'b1);
        word_last <= (CNT_W'(idx + 1'b1) == LAST_IDX);
      end
    end
  end

  // Select word idx, counting from the most-significant end of hold.
  always_comb begin
    word_sel = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (idx == CNT_W'(i)) begin
        word_sel = hold[DATA_W-1-i*WORD_W -: WORD_W];
      end
    end
  end

`ifdef AES_RESULT_BYTE_SWAP_EN
  // Reverse byte lanes so AES state bytes arrive little-endian at the core.
  always_comb begin
    word_out = '0;
    for (int unsigned b = 0; b < WORD_W / 8; b++) begin
      word_out[b*8 +: 8] = word_sel[WORD_W-1-b*8 -: 8];
    end
  end
`else
  assign word_out = word_sel;
`endif

endmodule

// File: tb/tb_aes_result_serializer.sv
// Self-checking bench for aes_result_serializer: directed vector table plus
// randomized traffic against a queue-of-words reference model.
module tb_aes_result_serializer;

  localparam int unsigned DW = 128;
  localparam int unsigned WW = 32;
  localparam int unsigned NW = DW / WW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] busR;
  logic          busR_valid;
  logic          busR_ready;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          word_ready;
  logic          word_last;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  aes_result_serializer #(.DATA_W(DW), .WORD_W(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .busR       (busR),
    .busR_valid (busR_valid),
    .busR_ready (busR_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_last  (word_last),
    .busy       (busy)
  );

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_RESULT_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic v, input logic [DW-1:0] d, input logic wr);
    rst        = r;
    busR_valid = v;
    busR       = d;
    word_ready = wr;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of words still owed from the held block.
  logic [31:0] q[$];

  task automatic check_model();
    int unsigned n;
    logic        er;
    n  = q.size();
    er = (n == 0) || (n == 1 && word_ready);
    chk("rnd_valid", 32'(word_valid), 32'(n != 0));
    chk("rnd_ready", 32'(busR_ready), 32'(er));
    chk("rnd_last",  32'(word_last),  32'(n == 1));
    chk("rnd_busy",  32'(busy),       32'(n != 0));
    if (n != 0) chk("rnd_word", word_out, q[0]);
  endtask

  task automatic model_cycle(input logic r, input logic v, input logic [DW-1:0] d,
                             input logic wr, output logic cap);
    int unsigned n;
    logic        er;
    n   = q.size();
    er  = (n == 0) || (n == 1 && wr);
    cap = 1'b0;
    if (r) begin
      q.delete();
    end else begin
      if (n != 0 && wr) void'(q.pop_front());
      if (v && er) begin
        cap = 1'b1;
        for (int i = 0; i < int'(NW); i++) q.push_back(sw(d[DW-1-i*WW -: WW]));
      end
    end
  endtask

  typedef struct {
    logic          r;
    logic          v;
    logic [DW-1:0] d;
    logic          wr;
    logic          ev;
    logic          er;
    logic          el;
    logic          cw;
    logic [31:0]   ew;
  } vec_t;

  vec_t tv[24];

  localparam logic [DW-1:0] BD = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] BA = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [DW-1:0] BB = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  logic          pend;
  logic [DW-1:0] blk;
  logic          cap;
  logic          r_i;
  logic          wr_i;

  initial begin
    // single block, stall on word 1 (busR_valid high but ignored)
    tv[0]  = '{1'b0, 1'b1, BD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 1'b0, BD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'h00112233)};
    tv[2]  = '{1'b0, 1'b1, BA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'h44556677)};
    tv[3]  = '{1'b0, 1'b1, BA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'h44556677)};
    tv[4]  = '{1'b0, 1'b1, BA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'h44556677)};
    tv[5]  = '{1'b0, 1'b0, BD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'h44556677)};
    tv[6]  = '{1'b0, 1'b0, BD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'h8899AABB)};
    tv[7]  = '{1'b0, 1'b0, BD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, sw(32'hCCDDEEFF)};
    // back-to-back A then B with busR_valid held
    tv[8]  = '{1'b0, 1'b1, BA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tv[9]  = '{1'b0, 1'b1, BB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'hA0A1A2A3)};
    tv[10] = '{1'b0, 1'b1, BB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'hB0B1B2B3)};
    tv[11] = '{1'b0, 1'b1, BB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'hC0C1C2C3)};
    tv[12] = '{1'b0, 1'b1, BB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, sw(32'hD0D1D2D3)};
    tv[13] = '{1'b0, 1'b0, BB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'h0F1E2D3C)};
    tv[14] = '{1'b0, 1'b0, BB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'h4B5A6978)};
    tv[15] = '{1'b0, 1'b0, BB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'h8796A5B4)};
    tv[16] = '{1'b0, 1'b0, BB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, sw(32'hC3D2E1F0)};
    tv[17] = '{1'b0, 1'b0, BB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    // reset after word 1 of a block
    tv[18] = '{1'b0, 1'b1, BA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tv[19] = '{1'b0, 1'b0, BA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'hA0A1A2A3)};
    tv[20] = '{1'b0, 1'b0, BA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'hB0B1B2B3)};
    tv[21] = '{1'b1, 1'b0, BA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sw(32'hC0C1C2C3)};
    tv[22] = '{1'b0, 1'b0, BA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    tv[23] = '{1'b0, 1'b0, BA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

    drive(1'b1, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("rst_ready", 32'(busR_ready), 32'h1);
    chk("rst_valid", 32'(word_valid), 32'h0);
    chk("rst_busy",  32'(busy),       32'h0);
    chk("rst_last",  32'(word_last),  32'h0);
    chk("rst_word",  word_out,        32'h0);
    next_cycle();

    for (int k = 0; k < 24; k++) begin
      drive(tv[k].r, tv[k].v, tv[k].d, tv[k].wr);
      chk($sformatf("tv%0d_valid", k), 32'(word_valid), 32'(tv[k].ev));
      chk($sformatf("tv%0d_ready", k), 32'(busR_ready), 32'(tv[k].er));
      chk($sformatf("tv%0d_last", k),  32'(word_last),  32'(tv[k].el));
      chk($sformatf("tv%0d_busy", k),  32'(busy),       32'(tv[k].ev));
      if (tv[k].cw) chk($sformatf("tv%0d_word", k), word_out, tv[k].ew);
      next_cycle();
    end

    q.delete();
    pend = 1'b0;
    blk  = '0;
    for (int c = 0; c < 800; c++) begin
      if (!pend && ($urandom_range(0, 1) == 1)) begin
        blk  = {$urandom, $urandom, $urandom, $urandom};
        pend = 1'b1;
      end
      r_i  = ($urandom_range(0, 63) == 0);
      wr_i = ($urandom_range(0, 3) != 0);
      drive(r_i, pend, blk, wr_i);
      check_model();
      model_cycle(r_i, pend, blk, wr_i, cap);
      if (cap) pend = 1'b0;
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
